// File: rtl/mult_share_scheduler_if.sv
// Request/response bundle between client logic and mult_share_scheduler.
// master: clients (drive requests, take responses); slave: scheduler.
interface mult_share_scheduler_if #(
  parameter int WORD_LENGTH = 4,
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*WORD_LENGTH-1:0] req_a;
  logic [NUM_REQ*WORD_LENGTH-1:0] req_b;
  logic [NUM_REQ-1:0] req_ready;
  logic resp_valid;
  logic [ID_W-1:0] resp_id;
  logic [2*WORD_LENGTH-1:0] resp_product;
  logic resp_ready;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_product
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_product
  );
endinterface

// File: rtl/mult_share_scheduler.sv
// Round-robin sharing of one accumulating multiplier among NUM_REQ clients.
// Ports: clk, reset (async, high), bus (req/resp), mul_* multiplier drive.
module mult_share_scheduler #(
  parameter int WORD_LENGTH = 4,
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic clk,
  input  logic reset,
  mult_share_scheduler_if.slave bus,
  output logic mul_start,
  output logic [WORD_LENGTH-1:0] mul_word0,
  output logic [WORD_LENGTH-1:0] mul_word1,
  input  logic [2*WORD_LENGTH-1:0] mul_product,
  input  logic mul_ready
);
  localparam int WL = WORD_LENGTH;
  localparam int SW = ID_W + 1;

  typedef enum logic [2:0] {
    IDLE, FLUSH, LOAD, WAIT, RESP
  } state_t;

  state_t state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] id_q;
  logic [WL-1:0] a_q;
  logic [WL-1:0] b_q;
  logic [2*WL-1:0] res_q;
  logic resp_v;

  logic [NUM_REQ-1:0] rot;
  logic [SW-1:0] sum;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] nxt_rr;
  logic grant_any;
  logic take;
  logic zero_op;
  logic [WL-1:0] sel_a;
  logic [WL-1:0] sel_b;

  // rot[j] is requester (rr_ptr+j) mod NUM_REQ; lowest j wins.
  always_comb begin
    rot = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
    grant_any = 1'b0;
    sum = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        grant_any = 1'b1;
        sum = {1'b0, rr_ptr} + SW'(j);
      end
    end
    if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
    grant_id = sum[ID_W-1:0];
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_id == ID_W'(j)) begin
        sel_a = bus.req_a[j*WL +: WL];
        sel_b = bus.req_b[j*WL +: WL];
      end
    end
  end

  assign nxt_rr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign take = (state == IDLE) && mul_ready && grant_any && !reset;
  assign zero_op = (a_q == '0) || (b_q == '0);

  assign bus.req_ready = take ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.resp_valid = resp_v;
  assign bus.resp_id = id_q;
  assign bus.resp_product = res_q;

  // Multiplier drive is registered: the value set on an edge is
  // what the multiplier sees during the following state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      resp_v <= 1'b0;
      mul_start <= 1'b0;
      mul_word0 <= '0;
      mul_word1 <= '0;
    end else begin
      mul_start <= 1'b0;
      mul_word0 <= '0;
      mul_word1 <= '0;
      unique case (state)
        IDLE: begin
          if (take) begin
            a_q <= sel_a;
            b_q <= sel_b;
            id_q <= grant_id;
            rr_ptr <= nxt_rr;
            // start with zero operands clears the accumulator
            mul_start <= 1'b1;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          state <= LOAD;
          if (!zero_op) begin
            mul_start <= 1'b1;
            mul_word0 <= a_q;
            mul_word1 <= b_q;
          end
        end
        LOAD: begin
          if (zero_op) begin
            res_q <= '0;
            resp_v <= 1'b1;
            state <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mul_ready) begin
            res_q <= mul_product;
            resp_v <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_v <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_scheduler.sv
// Self-checking bench for mult_share_scheduler with a behavioural
// accumulating-multiplier model and a queue-based reference model.
module tb_mult_share_scheduler;
  localparam int WL = 4;
  localparam int NR = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mult_share_scheduler_if #(
    .WORD_LENGTH(WL), .NUM_REQ(NR), .ID_W(IW)
  ) bus ();

  logic mul_start;
  logic [WL-1:0] mul_word0;
  logic [WL-1:0] mul_word1;
  logic [2*WL-1:0] mul_product;
  logic mul_ready;

  mult_share_scheduler #(
    .WORD_LENGTH(WL), .NUM_REQ(NR), .ID_W(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .mul_start(mul_start),
    .mul_word0(mul_word0),
    .mul_word1(mul_word1),
    .mul_product(mul_product),
    .mul_ready(mul_ready)
  );

  function automatic int kbits(int v);
    return $clog2(v + 1);
  endfunction

  function automatic int exp_grant(logic [NR-1:0] vld, int ptr);
    for (int j = 0; j < NR; j++) begin
      if (vld[(ptr + j) % NR]) return (ptr + j) % NR;
    end
    return -1;
  endfunction

  // accumulating multiplier: flush on zero operand, busy k cycles
  logic [2*WL-1:0] m_acc;
  logic [WL-1:0] m_a;
  logic [WL-1:0] m_b;
  int m_busy;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_acc <= '0;
      m_busy <= 0;
      m_a <= '0;
      m_b <= '0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) m_acc <= m_acc + {4'b0, m_a} * {4'b0, m_b};
    end else if (mul_start) begin
      if (mul_word0 == 0 || mul_word1 == 0) m_acc <= '0;
      else begin
        m_a <= mul_word0;
        m_b <= mul_word1;
        m_busy <= kbits(int'(mul_word1));
      end
    end
  end
  assign mul_ready = (m_busy == 0);
  assign mul_product = m_acc;

  typedef struct { int a; int b; } op_t;
  typedef struct { int t; int id; logic [NR-1:0] vld; } acc_t;
  typedef struct { int t; int id; int p; } rsp_t;
  typedef struct { int t; int w0; int w1; } st_t;

  op_t pq[NR][$];
  op_t expq[NR][$];
  acc_t accq[$];
  rsp_t riseq[$];
  rsp_t hsq[$];
  st_t stq[$];
  int viol = 0;
  int cyc = 0;
  bit rand_bp = 1'b0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // negedge monitor: logs accepts, responses, multiplier starts
  logic prev_rv = 1'b0;
  int mn, mid;
  acc_t ea;
  rsp_t er;
  st_t es0;
  initial forever begin
    @(negedge clk);
    if (reset) prev_rv = 1'b0;
    else begin
      if (bus.req_ready != '0) begin
        mn = 0;
        mid = 0;
        for (int i = 0; i < NR; i++)
          if (bus.req_ready[i]) begin mn++; mid = i; end
        if (mn != 1 || !bus.req_valid[mid] || bus.resp_valid) viol++;
        ea.t = cyc + 1; ea.id = mid; ea.vld = bus.req_valid;
        accq.push_back(ea);
      end
      if (mul_start) begin
        es0.t = cyc; es0.w0 = int'(mul_word0); es0.w1 = int'(mul_word1);
        stq.push_back(es0);
      end
      er.t = cyc; er.id = int'(bus.resp_id); er.p = int'(bus.resp_product);
      if (bus.resp_valid && !prev_rv) riseq.push_back(er);
      if (bus.resp_valid && bus.resp_ready) hsq.push_back(er);
      prev_rv = bus.resp_valid;
    end
  end

  task automatic post(int i, int a, int b);
    op_t o;
    o.a = a; o.b = b;
    pq[i].push_back(o);
    expq[i].push_back(o);
  endtask

  task automatic load_next(int i);
    op_t o;
    if (pq[i].size() > 0) begin
      o = pq[i].pop_front();
      bus.req_a[i*WL +: WL] = WL'(o.a);
      bus.req_b[i*WL +: WL] = WL'(o.b);
      bus.req_valid[i] = 1'b1;
    end else bus.req_valid[i] = 1'b0;
  endtask

  task automatic kick();
    for (int i = 0; i < NR; i++) if (!bus.req_valid[i]) load_next(i);
  endtask

  task automatic tick();
    logic [NR-1:0] rdy;
    @(negedge clk);
    rdy = bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (rdy[i]) load_next(i);
    if (rand_bp) bus.resp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run_until(int n, int budget, output bit ok);
    int c;
    c = 0;
    while (hsq.size() < n && c < budget) begin tick(); c++; end
    ok = (hsq.size() >= n);
  endtask

  task automatic clear_logs();
    accq.delete(); riseq.delete(); hsq.delete(); stq.delete();
    viol = 0;
  endtask

  task automatic drop_pending();
    bus.req_valid = '0;
    for (int i = 0; i < NR; i++) begin pq[i].delete(); expq[i].delete(); end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drop_pending();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    bus.req_valid = '1; bus.req_a = '1; bus.req_b = '1;
    bus.resp_ready = 1'b1;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== '0) begin errors++;
      $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_id !== '0) begin errors++;
      $display("FAIL reset_resp: valid %b id %0d want 0 0", bus.resp_valid, bus.resp_id); end
    checks++;
    if (bus.resp_product !== '0) begin errors++;
      $display("FAIL reset_product: got %0d want 0", bus.resp_product); end
    checks++;
    if ({mul_start, mul_word0, mul_word1} !== '0) begin errors++;
      $display("FAIL reset_mul: start %b w0 %0d w1 %0d want 0", mul_start, mul_word0, mul_word1); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== '0 || bus.resp_valid !== 1'b0) begin errors++;
      $display("FAIL reset_hold: req_ready %b resp_valid %b want 0", bus.req_ready, bus.resp_valid); end
    drop_pending();
    #1 reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    post(2, 13, 11); kick();
    run_until(1, 60, ok);
    checks++;
    if (!ok || accq.size() != 1 || riseq.size() != 1) begin errors++;
      $display("FAIL single_count: acc %0d resp %0d want 1 1", accq.size(), hsq.size()); end
    else begin
      checks++;
      if (accq[0].id !== 2) begin errors++;
        $display("FAIL single_grant: got %0d want 2", accq[0].id); end
      checks++;
      if (riseq[0].t - accq[0].t !== 7) begin errors++;
        $display("FAIL single_latency: got %0d want 7", riseq[0].t - accq[0].t); end
      checks++;
      if (hsq[0].id !== 2 || hsq[0].p !== 143) begin errors++;
        $display("FAIL single_resp: id %0d prod %0d want 2 143", hsq[0].id, hsq[0].p); end
      checks++;
      if (stq.size() != 2 || stq[0].t != accq[0].t || stq[0].w0 != 0 || stq[0].w1 != 0
          || stq[1].t != accq[0].t + 1 || stq[1].w0 != 13 || stq[1].w1 != 11) begin errors++;
        $display("FAIL single_starts: %0d start pulses, want flush then load 13*11", stq.size()); end
    end
  endtask

  task automatic test_stale();
    bit ok;
    clear_logs();
    post(0, 15, 15); post(0, 7, 7); kick();
    run_until(2, 80, ok);
    checks++;
    if (!ok || accq.size() != 2) begin errors++;
      $display("FAIL stale_count: resp %0d want 2", hsq.size()); end
    else begin
      checks++;
      if (hsq[0].p !== 225 || hsq[1].p !== 49) begin errors++;
        $display("FAIL stale_products: got %0d %0d want 225 49", hsq[0].p, hsq[1].p); end
      checks++;
      if (stq.size() != 4) begin errors++;
        $display("FAIL stale_start_count: got %0d want 4", stq.size()); end
      else begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (stq[2*k].t != accq[k].t || stq[2*k].w0 != 0 || stq[2*k].w1 != 0
              || stq[2*k+1].t != accq[k].t + 1 || stq[2*k+1].w0 == 0) begin errors++;
            $display("FAIL stale_flush_%0d: flush at %0d (%0d,%0d) accept %0d want flush next cycle",
                     k, stq[2*k].t, stq[2*k].w0, stq[2*k].w1, accq[k].t); end
        end
      end
    end
  endtask

  task automatic test_zero();
    bit ok;
    int n;
    clear_logs();
    post(2, 13, 11); kick();
    run_until(1, 60, ok);
    post(1, 0, 9); kick();
    run_until(2, 60, ok);
    checks++;
    if (!ok || accq.size() != 2 || riseq.size() != 2) begin errors++;
      $display("FAIL zero_count: resp %0d want 2", hsq.size()); end
    else begin
      checks++;
      if (hsq[0].p !== 143 || hsq[1].id !== 1 || hsq[1].p !== 0) begin errors++;
        $display("FAIL zero_resp: %0d then id %0d prod %0d want 143 then 1 0",
                 hsq[0].p, hsq[1].id, hsq[1].p); end
      checks++;
      if (riseq[1].t - accq[1].t !== 2) begin errors++;
        $display("FAIL zero_latency: got %0d want 2", riseq[1].t - accq[1].t); end
      n = 0;
      foreach (stq[k]) if (stq[k].t >= accq[1].t) n++;
      checks++;
      if (n != 1 || stq[stq.size()-1].w0 != 0 || stq[stq.size()-1].w1 != 0) begin errors++;
        $display("FAIL zero_no_load: %0d start pulses after accept, want 1 flush", n); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    post(0, 1, 3); post(0, 1, 3);
    post(1, 2, 3); post(2, 3, 3); post(3, 4, 3);
    kick();
    run_until(5, 200, ok);
    checks++;
    if (!ok || accq.size() != 5) begin errors++;
      $display("FAIL rr_count: resp %0d want 5", hsq.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (accq[k].id !== order[k] || hsq[k].id !== order[k]
            || hsq[k].p !== (order[k] + 1) * 3) begin errors++;
          $display("FAIL rr_%0d: grant %0d prod %0d want %0d %0d",
                   k, accq[k].id, hsq[k].p, order[k], (order[k] + 1) * 3); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int c;
    clear_logs();
    bus.resp_ready = 1'b0;
    post(3, 5, 6); post(0, 2, 2); kick();
    c = 0;
    while (!bus.resp_valid && c < 40) begin tick(); c++; end
    checks++;
    if (bus.resp_valid !== 1'b1) begin errors++;
      $display("FAIL bp_timeout: resp_valid %b want 1", bus.resp_valid); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd3 || bus.resp_product !== 8'd30
          || bus.req_ready !== '0) begin errors++;
        $display("FAIL bp_hold_%0d: v %b id %0d p %0d rdy %b want 1 3 30 0000", k,
                 bus.resp_valid, bus.resp_id, bus.resp_product, bus.req_ready); end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || hsq.size() != 1) begin errors++;
      $display("FAIL bp_release: resp_valid %b handshakes %0d want 0 1", bus.resp_valid, hsq.size()); end
    run_until(2, 60, ok);
    checks++;
    if (!ok) begin errors++;
      $display("FAIL bp_next: handshakes %0d want 2", hsq.size()); end
    else if (hsq[1].id !== 0 || hsq[1].p !== 4) begin errors++;
      $display("FAIL bp_next: id %0d prod %0d want 0 4", hsq[1].id, hsq[1].p); end
    checks++;
    if (viol != 0) begin errors++;
      $display("FAIL bp_protocol: %0d bad req_ready cycles want 0", viol); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int c;
    clear_logs();
    post(1, 15, 15); kick();
    c = 0; seen = 1'b0;
    while (!seen && c < 40) begin
      tick(); c++;
      foreach (stq[k]) if (stq[k].w0 == 15) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++;
      $display("FAIL rst_mid_load: load pulse seen %b want 1", seen); end
    reset = 1'b1;
    #1;
    checks++;
    if ({mul_start, mul_word0, mul_word1} !== '0 || bus.resp_valid !== 1'b0
        || bus.resp_id !== '0 || bus.resp_product !== '0 || bus.req_ready !== '0) begin errors++;
      $display("FAIL rst_mid_outputs: start %b v %b id %0d p %0d want all 0",
               mul_start, bus.resp_valid, bus.resp_id, bus.resp_product); end
    drop_pending();
    @(posedge clk);
    #1 reset = 1'b0;
    clear_logs();
    repeat (10) tick();
    checks++;
    if (hsq.size() != 0 || riseq.size() != 0 || bus.resp_valid !== 1'b0) begin errors++;
      $display("FAIL rst_mid_dropped: %0d responses want 0", riseq.size()); end
    post(2, 2, 3); kick();
    run_until(1, 60, ok);
    checks++;
    if (!ok) begin errors++;
      $display("FAIL rst_mid_after: handshakes %0d want 1", hsq.size()); end
    else if (hsq[0].id !== 2 || hsq[0].p !== 6) begin errors++;
      $display("FAIL rst_mid_after: id %0d prod %0d want 2 6", hsq[0].id, hsq[0].p); end
  endtask

  task automatic test_random();
    bit ok;
    int rr, g, a, b, lat;
    op_t o;
    st_t e;
    st_t es[$];
    do_reset();
    rand_bp = 1'b1;
    for (int k = 0; k < 30; k++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) a = 0;
      post(int'($urandom_range(0, NR - 1)), a, b);
    end
    kick();
    run_until(30, 3000, ok);
    rand_bp = 1'b0;
    bus.resp_ready = 1'b1;
    checks++;
    if (!ok || accq.size() != 30 || riseq.size() != 30) begin errors++;
      $display("FAIL rand_count: acc %0d resp %0d want 30 30", accq.size(), hsq.size()); end
    else begin
      rr = 0;
      for (int k = 0; k < 30; k++) begin
        g = exp_grant(accq[k].vld, rr);
        if (g < 0) g = 0;
        rr = (g + 1) % NR;
        checks++;
        if (accq[k].id !== g) begin errors++;
          $display("FAIL rand_grant_%0d: got %0d want %0d", k, accq[k].id, g); end
        o.a = 0; o.b = 0;
        if (expq[g].size() > 0) o = expq[g].pop_front();
        a = o.a; b = o.b;
        lat = (a == 0 || b == 0) ? 2 : kbits(b) + 3;
        checks++;
        if (riseq[k].t - accq[k].t !== lat) begin errors++;
          $display("FAIL rand_latency_%0d: got %0d want %0d", k, riseq[k].t - accq[k].t, lat); end
        checks++;
        if (hsq[k].id !== g || hsq[k].p !== a * b) begin errors++;
          $display("FAIL rand_resp_%0d: id %0d prod %0d want %0d %0d", k, hsq[k].id, hsq[k].p, g, a * b); end
        e.t = accq[k].t; e.w0 = 0; e.w1 = 0;
        es.push_back(e);
        if (a != 0 && b != 0) begin
          e.t = accq[k].t + 1; e.w0 = a; e.w1 = b;
          es.push_back(e);
        end
      end
      checks++;
      if (stq.size() != es.size()) begin errors++;
        $display("FAIL rand_start_count: got %0d want %0d", stq.size(), es.size()); end
      else begin
        foreach (es[k]) begin
          checks++;
          if (stq[k].t != es[k].t || stq[k].w0 != es[k].w0 || stq[k].w1 != es[k].w1) begin errors++;
            $display("FAIL rand_start_%0d: t %0d (%0d,%0d) want t %0d (%0d,%0d)", k,
                     stq[k].t, stq[k].w0, stq[k].w1, es[k].t, es[k].w0, es[k].w1); end
        end
      end
      checks++;
      if (viol != 0) begin errors++;
        $display("FAIL rand_protocol: %0d bad req_ready cycles want 0", viol); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_stale();
    test_zero();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_share_scheduler.md
# mult_share_scheduler

Round-robin scheduler that shares one `asmd_multiplier` instance among `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes, then sequences the multiplier for each one. Each multiply is a flush, then a load/start, then a wait for completion. The result is returned on a single response channel tagged with the requester index. The block sits between client logic and the multiplier and is the multiplier's only driver of `start`, `word0` and `word1`.

## Interface
- `WORD_LENGTH`, default 4: operand width; must match the multiplier's `word_length`.
- `NUM_REQ`, default 4: number of requesters (2..8).
- `ID_W`, default 2: response tag width, equal to clog2(`NUM_REQ`).
- Reset is `reset`: asynchronous, active-high. The clock is `clk`.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high; the same net drives the multiplier's reset.
- `req_valid`, input, `NUM_REQ`: bit i high means requester i has an operand pair pending.
- `req_a`, input, `NUM_REQ`*`WORD_LENGTH`: multiplicands; slice i belongs to requester i.
- `req_b`, input, `NUM_REQ`*`WORD_LENGTH`: multipliers; slice i belongs to requester i.
- `req_ready`, output, `NUM_REQ`: one-hot accept pulse; operands are captured on the edge where it is high.
- `resp_valid`, output, 1: response available.
- `resp_id`, output, `ID_W`: index of the requester that owns the response.
- `resp_product`, output, 2*`WORD_LENGTH`: the product a*b.
- `resp_ready`, input, 1: the consumer takes the response on the edge where `resp_valid` and `resp_ready` are both high.
- `mul_start`, output, 1: drives the multiplier's `start`.
- `mul_word0`, output, `WORD_LENGTH`: drives the multiplier's `word0`.
- `mul_word1`, output, `WORD_LENGTH`: drives the multiplier's `word1`.
- `mul_product`, input, 2*`WORD_LENGTH`: the multiplier's `product`.
- `mul_ready`, input, 1: the multiplier's `ready`; high only while the multiplier is idle.

## Operation

**Multiplier properties this block relies on**
- The multiplier's product register accumulates. It is cleared only by `reset`, or by `start` presented with a zero operand (flush).
- Every multiply therefore needs a flush before the load.

**FSM states:** IDLE, FLUSH, LOAD, WAIT, RESP.

- **IDLE**
  - If any `req_valid` is set and `mul_ready`=1, grant the first set bit searching from `rr_ptr` upward with wrap-around.
  - `req_ready[grant]` is combinational: IDLE & `mul_ready` & grant.
  - On that edge: capture a, b and grant id; set `rr_ptr` to (grant+1) mod `NUM_REQ`; go to FLUSH.
- **FLUSH**
  - Drive `mul_start`=1 with `mul_word0`=`mul_word1`=0 for exactly one cycle.
  - Go to LOAD.
- **LOAD**
  - If the captured a==0 or b==0: drive `mul_start`=0, set the result register to 0, go to RESP.
  - Otherwise: drive `mul_start`=1 with `mul_word0`=a and `mul_word1`=b, go to WAIT.
- **WAIT**
  - Hold `mul_start`=0.
  - When `mul_ready`=1, capture `mul_product` into the result register and go to RESP.
  - `mul_ready` is guaranteed low in the first WAIT cycle because the multiplier is in its running state.
- **RESP**
  - Assert `resp_valid` with `resp_id` and `resp_product` taken from the registers; hold them stable.
  - When `resp_ready`=1, go to IDLE.
  - No new grant is made while in RESP.

**Output defaults:** `mul_start`=0 and `mul_word0`=`mul_word1`=0 whenever they are not driven as above. Only one transaction is in flight at a time.

**Width rules:** the product is 2*`WORD_LENGTH` bits and cannot overflow. Operands are treated as unsigned.

## Timing

**Reset values:** all outputs 0, state IDLE, `rr_ptr`=0, result and id registers 0.

**Reset mid-operation:** the in-flight transaction is dropped with no response. The multiplier resets at the same time.

**Latency**, counted from the accept edge to the first cycle with `resp_valid` high:
- Nonzero operands: k+3 cycles, where k = (index of the most-significant set bit of b)+1.
  - b=1 gives 4 cycles.
  - b=15 gives 7 cycles.
- Any zero operand: 2 cycles.

**Throughput:**
- The next accept can happen in the cycle after the response handshake, at the earliest.
- `req_ready` cannot be high in the same cycle as `resp_valid`.

**Requester side:**
- Requesters hold `req_valid`, `req_a` and `req_b` stable until `req_ready` is seen.
- Deasserting `req_valid` before the grant withdraws the request legally.

**Arbitration fairness:** with all requesters continuously valid, grants rotate 0,1,..,`NUM_REQ`-1,0.

**Multiplier busy:** if `mul_ready`=0 in IDLE (not expected in normal use), no grant is made.

## Test plan
1. **Single multiply.** Requester 2 sends a=13, b=11 → `req_ready[2]` pulses once; `resp_valid` rises 7 cycles after accept with `resp_id`=2 and `resp_product`=143.
2. **Stale-result check.** Requester 0 sends 15*15, then requester 0 sends 7*7 → responses 225, then 49 (not 274). Also confirm exactly one flush-cycle `mul_start` precedes each load.
3. **Zero operand.** Requester 1 sends 0*9 right after a 143 result → `resp_product`=0 at latency 2; no load `mul_start` is issued.
4. **Round-robin.** All 4 requesters are valid from reset with a=i+1, b=3 → grant order 0,1,2,3,0; products 3,6,9,12; `rr_ptr` wraps back to 0.
5. **Back-pressure.** Hold `resp_ready`=0 for 5 cycles during RESP → `resp_valid`, `resp_id` and `resp_product` stay constant, and no `req_ready` is asserted; the handshake completes on the first cycle `resp_ready`=1.
6. **Reset mid-run.** Assert `reset` during WAIT of 15*15 → all outputs go to 0 immediately and no response is produced; a following 2*3 request returns 6.
